// File: rtl/hopfield_seq_controller.sv
// rtl/hopfield_seq_controller.sv - sequencing FSM for the Hopfield neuron-layer datapath
// Drives MAC, activation and state-memory write strobes; ends on convergence or iteration cap.
module hopfield_seq_controller #(
   parameter int N_IN     = 4,
   parameter int N_NEURON = 4,
   parameter int MAX_ITER = 16,
   parameter int IDX_W    = $clog2(N_IN),
   parameter int NEU_W    = $clog2(N_NEURON),
   parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              converged,
   output logic              en_x,
   output logic              en_w,
   output logic              init_mux,
   output logic              clr_acc,
   output logic              en_acc,
   output logic              en_a,
   output logic              wr_en,
   output logic [IDX_W-1:0]  in_idx,
   output logic [NEU_W-1:0]  neu_idx,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              busy,
   output logic              done,
   output logic              timeout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_CLR   = 3'd2;
   localparam logic [2:0] S_MAC   = 3'd3;
   localparam logic [2:0] S_ACT   = 3'd4;
   localparam logic [2:0] S_WRITE = 3'd5;
   localparam logic [2:0] S_CHECK = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_IN - 1);
   localparam logic [NEU_W-1:0]  NEU_LAST  = NEU_W'(N_NEURON - 1);
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [IDX_W-1:0]  r_in_idx;
   logic [NEU_W-1:0]  r_neu_idx;
   logic [ITER_W-1:0] r_iter_cnt;
   logic              r_timeout;
   logic              w_cap_hit;

   assign w_cap_hit = (r_iter_cnt == ITER_LAST);

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = start ? S_INIT : S_IDLE;
         S_INIT:  w_next = S_CLR;
         S_CLR:   w_next = S_MAC;
         S_MAC:   w_next = (r_in_idx == IDX_LAST) ? S_ACT : S_MAC;
         S_ACT:   w_next = S_WRITE;
         S_WRITE: w_next = (r_neu_idx == NEU_LAST) ? S_CHECK : S_CLR;
         S_CHECK: w_next = (converged || w_cap_hit) ? S_DONE : S_CLR;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_in_idx   <= '0;
         r_neu_idx  <= '0;
         r_iter_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_INIT: begin
               r_neu_idx  <= '0;
               r_iter_cnt <= '0;
               r_timeout  <= 1'b0;
            end
            S_CLR: r_in_idx <= '0;
            S_MAC: begin
               if (r_in_idx != IDX_LAST) begin
                  r_in_idx <= r_in_idx + IDX_W'(1);
               end
            end
            S_WRITE: r_neu_idx <= (r_neu_idx == NEU_LAST) ? '0 : r_neu_idx + NEU_W'(1);
            // convergence takes priority over the cap, so timeout only when not converged
            S_CHECK: begin
               r_iter_cnt <= r_iter_cnt + ITER_W'(1);
               r_timeout  <= !converged && w_cap_hit;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      en_x     = 1'b0;
      en_w     = 1'b0;
      init_mux = 1'b0;
      clr_acc  = 1'b0;
      en_acc   = 1'b0;
      en_a     = 1'b0;
      wr_en    = 1'b0;
      case (r_state)
         S_INIT: begin
            en_x     = 1'b1;
            en_w     = 1'b1;
            init_mux = 1'b1;
         end
         S_CLR:   clr_acc = 1'b1;
         S_MAC:   en_acc  = 1'b1;
         S_ACT:   en_a    = 1'b1;
         S_WRITE: wr_en   = 1'b1;
         S_CHECK: en_x    = 1'b1;
         default: ;
      endcase
   end

   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign in_idx   = r_in_idx;
   assign neu_idx  = r_neu_idx;
   assign iter_cnt = r_iter_cnt;
   assign timeout  = r_timeout;

endmodule

// File: tb/tb_hopfield_seq_controller.sv
// tb/tb_hopfield_seq_controller.sv - directed scoreboard bench for hopfield_seq_controller
// Three instances: defaults, N_IN=3/N_NEURON=5/MAX_ITER=2, and MAX_ITER=1.
module tb_hopfield_seq_controller;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic [2:0] start_v = '0;
   logic [2:0] conv_v  = '0;
   int         cyc     = 0;
   int         n_pass  = 0;
   int         n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   wire [2:0] en_x_v, en_w_v, init_mux_v, clr_acc_v, en_acc_v, en_a_v, wr_en_v;
   wire [2:0] busy_v, done_v, timeout_v;
   wire [1:0] in_idx_0, neu_idx_0;
   wire [4:0] iter_0;
   wire [1:0] in_idx_1;
   wire [2:0] neu_idx_1;
   wire [1:0] iter_1;
   wire [1:0] in_idx_2, neu_idx_2;
   wire [0:0] iter_2;
   wire [7:0] in_idx_v [3];
   wire [7:0] neu_idx_v [3];
   wire [7:0] iter_v [3];

   assign in_idx_v[0]  = 8'(in_idx_0);
   assign in_idx_v[1]  = 8'(in_idx_1);
   assign in_idx_v[2]  = 8'(in_idx_2);
   assign neu_idx_v[0] = 8'(neu_idx_0);
   assign neu_idx_v[1] = 8'(neu_idx_1);
   assign neu_idx_v[2] = 8'(neu_idx_2);
   assign iter_v[0]    = 8'(iter_0);
   assign iter_v[1]    = 8'(iter_1);
   assign iter_v[2]    = 8'(iter_2);

   hopfield_seq_controller #(.N_IN(4), .N_NEURON(4), .MAX_ITER(16)) u_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .converged(conv_v[0]),
      .en_x(en_x_v[0]), .en_w(en_w_v[0]), .init_mux(init_mux_v[0]), .clr_acc(clr_acc_v[0]),
      .en_acc(en_acc_v[0]), .en_a(en_a_v[0]), .wr_en(wr_en_v[0]),
      .in_idx(in_idx_0), .neu_idx(neu_idx_0), .iter_cnt(iter_0),
      .busy(busy_v[0]), .done(done_v[0]), .timeout(timeout_v[0]));

   hopfield_seq_controller #(.N_IN(3), .N_NEURON(5), .MAX_ITER(2)) u_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .converged(conv_v[1]),
      .en_x(en_x_v[1]), .en_w(en_w_v[1]), .init_mux(init_mux_v[1]), .clr_acc(clr_acc_v[1]),
      .en_acc(en_acc_v[1]), .en_a(en_a_v[1]), .wr_en(wr_en_v[1]),
      .in_idx(in_idx_1), .neu_idx(neu_idx_1), .iter_cnt(iter_1),
      .busy(busy_v[1]), .done(done_v[1]), .timeout(timeout_v[1]));

   hopfield_seq_controller #(.N_IN(4), .N_NEURON(4), .MAX_ITER(1)) u_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .converged(conv_v[2]),
      .en_x(en_x_v[2]), .en_w(en_w_v[2]), .init_mux(init_mux_v[2]), .clr_acc(clr_acc_v[2]),
      .en_acc(en_acc_v[2]), .en_a(en_a_v[2]), .wr_en(wr_en_v[2]),
      .in_idx(in_idx_2), .neu_idx(neu_idx_2), .iter_cnt(iter_2),
      .busy(busy_v[2]), .done(done_v[2]), .timeout(timeout_v[2]));

   localparam int P_NN [3] = '{4, 5, 4};

   // Passive strobe counters per run; a run is delimited by the INIT cycle (en_w).
   int t0 [3];
   int cnt_acc [3];
   int cnt_wr [3];
   int cnt_x [3];
   int seq_bad [3];
   int in_exp [3];

   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (rst) begin
            cnt_acc[g] <= 0;
            cnt_wr[g]  <= 0;
            cnt_x[g]   <= 0;
            seq_bad[g] <= 0;
            in_exp[g]  <= 0;
         end else if (en_w_v[g]) begin
            t0[g]      <= cyc;
            cnt_acc[g] <= 0;
            cnt_wr[g]  <= 0;
            cnt_x[g]   <= 1;
            seq_bad[g] <= 0;
            in_exp[g]  <= 0;
         end else begin
            if (en_acc_v[g]) cnt_acc[g] <= cnt_acc[g] + 1;
            if (wr_en_v[g])  cnt_wr[g]  <= cnt_wr[g] + 1;
            if (en_x_v[g])   cnt_x[g]   <= cnt_x[g] + 1;
            if (clr_acc_v[g])      in_exp[g] <= 0;
            else if (en_acc_v[g])  in_exp[g] <= in_exp[g] + 1;
            if ((en_acc_v[g] && int'(in_idx_v[g]) != in_exp[g]) ||
                (wr_en_v[g] && int'(neu_idx_v[g]) != cnt_wr[g] % P_NN[g]))
               seq_bad[g] <= seq_bad[g] + 1;
         end
      end
   end

   typedef struct {
      int edge_n;
      int iter;
      int tmo;
      int acc;
      int wr;
      int x;
   } exp_t;

   exp_t sb_q [$];

   task automatic chk(input string tag, input int obs, input int expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   function automatic exp_t expect_run(input int nin, input int nn, input int iters, input int tmo);
      exp_t e;
      e.edge_n = 1 + iters * (nn * (nin + 3) + 1);
      e.iter   = iters;
      e.tmo    = tmo;
      e.acc    = iters * nn * nin;
      e.wr     = iters * nn;
      e.x      = 1 + iters;
      return e;
   endfunction

   function automatic int strobes(input int d);
      return int'({en_x_v[d], en_w_v[d], init_mux_v[d], clr_acc_v[d], en_acc_v[d], en_a_v[d], wr_en_v[d]});
   endfunction

   task automatic pulse_start(input int d);
      @(negedge clk);
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
   endtask

   task automatic finish_run(input int d, input int limit);
      exp_t e;
      bit   seen = 1'b0;
      int   obs_edge = 0;
      for (int k = 0; k < limit && !seen; k++) begin
         @(negedge clk);
         #1;
         if (done_v[d]) begin
            seen     = 1'b1;
            obs_edge = cyc - t0[d];
         end
      end
      e = sb_q.pop_front();
      chk($sformatf("d%0d_done_seen", d), int'(seen), 1);
      if (seen) begin
         chk($sformatf("d%0d_done_edge", d), obs_edge, e.edge_n);
         chk($sformatf("d%0d_iter_cnt", d), int'(iter_v[d]), e.iter);
         chk($sformatf("d%0d_timeout", d), int'(timeout_v[d]), e.tmo);
         chk($sformatf("d%0d_busy_in_done", d), int'(busy_v[d]), 1);
         chk($sformatf("d%0d_en_acc_count", d), cnt_acc[d], e.acc);
         chk($sformatf("d%0d_wr_en_count", d), cnt_wr[d], e.wr);
         chk($sformatf("d%0d_en_x_count", d), cnt_x[d], e.x);
         chk($sformatf("d%0d_index_seq", d), seq_bad[d], 0);
         @(negedge clk);
         #1;
         chk($sformatf("d%0d_done_one_cycle", d), int'(done_v[d]), 0);
         chk($sformatf("d%0d_idle_after", d), int'(busy_v[d]), 0);
      end
   endtask

   initial begin
      bit saw_done;

      repeat (2) @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d_rst_busy", d), int'(busy_v[d]), 0);
         chk($sformatf("d%0d_rst_done", d), int'(done_v[d]), 0);
         chk($sformatf("d%0d_rst_timeout", d), int'(timeout_v[d]), 0);
         chk($sformatf("d%0d_rst_strobes", d), strobes(d), 0);
         chk($sformatf("d%0d_rst_in_idx", d), int'(in_idx_v[d]), 0);
         chk($sformatf("d%0d_rst_neu_idx", d), int'(neu_idx_v[d]), 0);
         chk($sformatf("d%0d_rst_iter", d), int'(iter_v[d]), 0);
      end
      rst = 1'b0;

      // converged held high: only the first CHECK matters
      conv_v[0] = 1'b1;
      sb_q.push_back(expect_run(4, 4, 1, 0));
      pulse_start(0);
      finish_run(0, 100);

      // never converges: runs to the cap
      conv_v[0] = 1'b0;
      sb_q.push_back(expect_run(4, 4, 16, 1));
      pulse_start(0);
      finish_run(0, 600);
      repeat (3) @(negedge clk);
      #1;
      chk("timeout_held", int'(timeout_v[0]), 1);
      chk("iter_held", int'(iter_v[0]), 16);
      conv_v[0] = 1'b1;
      sb_q.push_back(expect_run(4, 4, 1, 0));
      pulse_start(0);
      @(negedge clk);
      #1;
      chk("timeout_cleared_by_init", int'(timeout_v[0]), 0);
      chk("iter_cleared_by_init", int'(iter_v[0]), 0);
      finish_run(0, 100);

      // converged only at the second CHECK, plus stray converged and start mid-run
      conv_v[0] = 1'b0;
      sb_q.push_back(expect_run(4, 4, 2, 0));
      pulse_start(0);
      for (int k = 1; k <= 58; k++) begin
         @(negedge clk);
         start_v[0] = (k == 10 || k == 11);
         conv_v[0]  = (k >= 20 && k <= 22) || (k == 58);
      end
      finish_run(0, 100);
      conv_v[0] = 1'b0;

      // asynchronous reset during MAC of iteration 3
      pulse_start(0);
      repeat (61) @(negedge clk);
      #1;
      chk("pre_rst_en_acc", int'(en_acc_v[0]), 1);
      chk("pre_rst_iter", int'(iter_v[0]), 2);
      rst = 1'b1;
      #1;
      chk("async_rst_busy", int'(busy_v[0]), 0);
      chk("async_rst_strobes", strobes(0), 0);
      chk("async_rst_in_idx", int'(in_idx_v[0]), 0);
      chk("async_rst_neu_idx", int'(neu_idx_v[0]), 0);
      chk("async_rst_iter", int'(iter_v[0]), 0);
      saw_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (done_v[0] || busy_v[0]) saw_done = 1'b1;
      end
      chk("no_done_after_rst", int'(saw_done), 0);
      conv_v[0] = 1'b1;
      sb_q.push_back(expect_run(4, 4, 1, 0));
      pulse_start(0);
      finish_run(0, 100);
      conv_v[0] = 1'b0;

      // N_IN=3, N_NEURON=5, MAX_ITER=2, no convergence
      sb_q.push_back(expect_run(3, 5, 2, 1));
      pulse_start(1);
      finish_run(1, 200);

      // MAX_ITER=1: convergence beats the cap, then the cap alone
      conv_v[2] = 1'b1;
      sb_q.push_back(expect_run(4, 4, 1, 0));
      pulse_start(2);
      finish_run(2, 100);
      conv_v[2] = 1'b0;
      sb_q.push_back(expect_run(4, 4, 1, 1));
      pulse_start(2);
      finish_run(2, 100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hopfield_seq_controller.md
Name: hopfield_seq_controller

Overview:
- Parametrised sequencing FSM for the neuron-layer datapath.
- Replaces the single-cycle multiply and externally driven done loop with three internal counters: an N_IN-cycle MAC, a per-neuron write sweep, and an iteration counter.
- Finishes on a datapath convergence flag or on an iteration cap.
- Sits between the top-level start/done handshake and the x/w registers, accumulator, activation unit and state memory.

Parameters:
N_IN, 4, inputs per neuron (MAC cycles per neuron), >=2
N_NEURON, 4, neurons updated per iteration, >=2
MAX_ITER, 16, iteration cap before timeout, >=1
IDX_W, $clog2(N_IN), width of in_idx
NEU_W, $clog2(N_NEURON), width of neu_idx
ITER_W, $clog2(MAX_ITER+1), width of iter_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin run; sampled only in IDLE
converged  in  1  datapath: no neuron changed this iteration; sampled only in CHECK
en_x  out  1  load x register (INIT, CHECK)
en_w  out  1  load weight register (INIT)
init_mux  out  1  select external input into x (INIT)
clr_acc  out  1  clear accumulator
en_acc  out  1  accumulate w[neu_idx][in_idx]*x[in_idx]
en_a  out  1  latch activation result
wr_en  out  1  write activated neuron to state memory at neu_idx
in_idx  out  IDX_W  current MAC input index
neu_idx  out  NEU_W  current neuron index
iter_cnt  out  ITER_W  completed iterations in this run
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run
timeout  out  1  run ended at MAX_ITER without convergence; held until next accepted start

Behaviour:
- Moore FSM. Strobes decode combinationally from state only; indices and counters are registered.
- Reset: async to IDLE. All strobes, busy, done, timeout = 0. in_idx, neu_idx, iter_cnt = 0.
- IDLE: no strobes asserted. start=1 -> INIT; start=0 stays in IDLE.
- INIT (1 cycle): en_x, en_w, init_mux = 1. Clears neu_idx, iter_cnt and timeout. -> CLR.
- CLR (1 cycle): clr_acc=1; in_idx <= 0. -> MAC.
- MAC (N_IN cycles): en_acc=1; in_idx increments each cycle from 0 to N_IN-1. When in_idx==N_IN-1 -> ACT; in_idx does not wrap past N_IN-1.
- ACT (1 cycle): en_a=1. -> WRITE.
- WRITE (1 cycle): wr_en=1 at current neu_idx.
  - neu_idx==N_NEURON-1: neu_idx <= 0, -> CHECK.
  - otherwise: neu_idx++, -> CLR.
- CHECK (1 cycle): en_x=1, committing the new state vector as the next inputs; iter_cnt++.
  - converged=1 -> DONE, timeout=0.
  - converged=0 and iter_cnt==MAX_ITER-1 (pre-increment value) -> DONE, timeout <= 1.
  - otherwise -> CLR.
  - If converged and the cap coincide, convergence wins and timeout=0.
- DONE (1 cycle): done=1, busy=1. -> IDLE. iter_cnt and timeout hold until the next INIT.
- Iteration length = N_NEURON*(N_IN+3)+1 cycles (29 at defaults).
- done is high in the cycle beginning at clock edge 1+K*(iteration length) after the edge that sampled start, where K = iterations run.
- start while busy is ignored and causes no restart. start held high through DONE re-triggers one cycle after the return to IDLE.
- converged outside CHECK is ignored.
- rst mid-run: immediate return to IDLE and reset values; no done pulse.
- Illegal state encodings -> IDLE.

Test Plan:
- Defaults; rst, then start pulse; converged=1 at first CHECK -> done one cycle at edge 30 after start edge; iter_cnt=1; timeout=0; exactly 16 en_acc cycles, 4 wr_en pulses (neu_idx 0,1,2,3), 2 en_x pulses.
- Defaults; converged held 0 -> done at edge 1+16*29=465; iter_cnt=16; timeout=1, held until next start, then cleared in INIT.
- N_IN=3, N_NEURON=5, MAX_ITER=2; converged=0 -> in_idx sequence 0,1,2 per neuron; neu_idx 0..4; done at edge 1+2*31=63; timeout=1.
- Defaults; converged=1 at second CHECK only, start re-pulsed mid-run -> no restart; done at edge 59; iter_cnt=2; timeout=0.
- Defaults; rst asserted asynchronously during MAC of iteration 3 -> busy=0, all strobes 0, counters 0 before next clock edge; no done pulse; fresh start runs normally.
- MAX_ITER=1; converged=1 at the only CHECK -> timeout=0 (convergence beats cap); done at edge 30.
